// File: rtl/nibble_serial_addsub.sv
// Nibble-serial 16-bit adder/subtractor: one 4-bit slice per cycle, either as one
// carry-chained 16-bit op or as four independent saturating signed 4-bit lanes.
module nibble_serial_addsub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  input  logic        pad,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        carry;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic        op_pad;
  logic [11:0] acc;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic        cin;
  logic [4:0]  sum;
  logic        lane_ovf;
  logic [3:0]  lane;
  logic [15:0] full;
  logic        v16;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_nib    = op_a[{idx, 2'b00} +: 4];
    b_nib    = op_b[{idx, 2'b00} +: 4] ^ {4{op_sub}};
    cin      = (op_pad || idx == 2'd0) ? op_sub : carry;
    sum      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};
    lane_ovf = (a_nib[3] == b_nib[3]) && (sum[3] != a_nib[3]);
    lane     = sum[3:0];
    if (op_pad && lane_ovf) begin
      lane = a_nib[3] ? 4'h8 : 4'h7;
    end
    full = {lane, acc};
    // Signed overflow of the whole word, judged on the final (index-3) slice.
    if (op_sub) v16 = (op_a[15] != op_b[15]) && (lane[3] != op_a[15]);
    else        v16 = (op_a[15] == op_b[15]) && (lane[3] != op_a[15]);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      carry  <= 1'b0;
      op_a   <= 16'h0000;
      op_b   <= 16'h0000;
      op_sub <= 1'b0;
      op_pad <= 1'b0;
      acc    <= 12'h000;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 16'h0000;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            op_sub <= sub;
            op_pad <= pad;
            idx    <= 2'd0;
            carry  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc   <= {lane, acc[11:4]};
          carry <= sum[4];
          idx   <= idx + 2'd1;
          if (idx == 2'd3) begin
            result <= full;
            if (!op_pad) begin
              flag_z <= (full == 16'h0000);
              flag_n <= full[15];
              flag_v <= v16;
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench: an arithmetic reference model tracks every accepted op and a
// per-cycle compare process checks all outputs; directed scenarios pin known values.
module tb_nibble_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        pad = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_addsub dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .sub    (sub),
    .pad    (pad),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_result(input logic [15:0] x, input logic [15:0] y,
                                             input logic s, input logic p);
    logic [15:0] r;
    int sx, sy, t;
    r = '0;
    if (!p) begin
      r = s ? (x - y) : (x + y);
    end else begin
      for (int i = 0; i < 4; i++) begin
        sx = int'(x[4*i +: 4]);
        sy = int'(y[4*i +: 4]);
        if (sx > 7) sx = sx - 16;
        if (sy > 7) sy = sy - 16;
        t = s ? (sx - sy) : (sx + sy);
        if (t > 7)  t = 7;
        if (t < -8) t = -8;
        r[4*i +: 4] = 4'(t);
      end
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic s);
    int t;
    t = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    return (t > 32767) || (t < -32768);
  endfunction

  // Cycles left in the current op: 5 on acceptance, result lands when it reaches 1.
  int          m_left = 0;
  logic [15:0] m_a = '0, m_b = '0;
  logic        m_sub = 1'b0, m_pad = 1'b0;
  logic [15:0] m_res = '0;
  logic        m_z = 1'b0, m_v = 1'b0, m_n = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_res  <= '0;
      m_z    <= 1'b0;
      m_v    <= 1'b0;
      m_n    <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= 5;
        m_a    <= a;
        m_b    <= b;
        m_sub  <= sub;
        m_pad  <= pad;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_res <= ref_result(m_a, m_b, m_sub, m_pad);
        if (!m_pad) begin
          m_z <= (ref_result(m_a, m_b, m_sub, 1'b0) == 16'h0000);
          m_n <= ref_result(m_a, m_b, m_sub, 1'b0) >> 15;
          m_v <= ref_ovf(m_a, m_b, m_sub);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",   16'(busy),   16'(m_left != 0));
      check("done",   16'(done),   16'(m_left == 1));
      check("result", result,      m_res);
      check("flag_z", 16'(flag_z), 16'(m_z));
      check("flag_v", 16'(flag_v), 16'(m_v));
      check("flag_n", 16'(flag_n), 16'(m_n));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                       input logic xs, input logic xp, input logic hold);
    int lat, nbusy;
    lat = 0;
    nbusy = 0;
    @(posedge clk); #1;
    a = xa; b = xb; sub = xs; pad = xp; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (hold) begin
        a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom); pad = 1'($urandom);
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    check("latency", 16'(lat), 16'd5);
    check("busy_cycles", 16'(nbusy), 16'd5);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_after", 16'(busy), 16'd0);
  endtask

  initial begin
    // reset state
    #3;
    check("rst_busy",   16'(busy),   16'd0);
    check("rst_done",   16'(done),   16'd0);
    check("rst_result", result,      16'h0000);
    check("rst_flags",  16'({flag_z, flag_v, flag_n}), 16'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // V1
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("v1_result", result, 16'h8000);
    check("v1_zvn", 16'({flag_z, flag_v, flag_n}), 16'b011);
    // V2
    do_op(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("v2_result", result, 16'hFFFF);
    check("v2_zvn", 16'({flag_z, flag_v, flag_n}), 16'b001);
    // V3
    do_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
    check("v3_result", result, 16'h0000);
    check("v3_zvn", 16'({flag_z, flag_v, flag_n}), 16'b100);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("v3b_result", result, 16'h7FFF);
    check("v3b_zvn", 16'({flag_z, flag_v, flag_n}), 16'b010);
    // V4: lane mode leaves flags from V3b untouched
    do_op(16'h783F, 16'h1821, 1'b0, 1'b1, 1'b0);
    check("v4_result", result, 16'h7850);
    check("v4_zvn", 16'({flag_z, flag_v, flag_n}), 16'b010);
    // V5: start held high through RUN and DONE with changing operands
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    check("v5_result", result, 16'h3333);

    // V6: reset during RUN index 2
    @(posedge clk); #1;
    a = 16'h0101; b = 16'h0202; sub = 1'b0; pad = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("v6_busy",   16'(busy),   16'd0);
    check("v6_done",   16'(done),   16'd0);
    check("v6_result", result,      16'h0000);
    check("v6_flags",  16'({flag_z, flag_v, flag_n}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("v6_no_done", 16'(done), 16'd0);
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    check("v6_after", result, 16'h0007);

    // randomized ops, checked cycle by cycle against the model
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list (name, direction, width, meaning) SHALL be:
  clk     in   1   rising-edge clock
  rst_n   in   1   async active-low reset
  start   in   1   request; sampled only in IDLE
  a       in   16  operand A
  b       in   16  operand B
  sub     in   1   1 = A - B, 0 = A + B
  pad     in   1   1 = four independent saturating signed 4-bit lanes; 0 = one 16-bit op
  busy    out  1   high in every state except IDLE
  done    out  1   one-cycle pulse, result valid
  result  out  16  registered result, held until the next completion
  flag_z  out  1   zero flag
  flag_v  out  1   signed-overflow flag
  flag_n  out  1   negative flag

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-004 IDLE with start=1 at a clock edge SHALL:
  - latch a, b, sub, pad
  - clear the nibble index to 0
  - go to RUN.
REQ-005 RUN SHALL process one nibble per cycle, index 0 to 3, LSB nibble first.
  - Nibble n sum = A[n] + (sub ? ~B[n] : B[n]) + cin.
REQ-006 When pad=0:
  - nibble 0 cin = sub
  - nibble 1-3 cin = registered carry-out of the previous nibble.
REQ-007 When pad=1:
  - every nibble's cin = sub; no carry passes between nibbles
  - on signed 4-bit overflow the lane SHALL saturate to 4'h7 (positive overflow) or 4'h8 (negative overflow).
REQ-008 After the index-3 cycle the FSM SHALL go to DONE.
  - The full 16-bit result SHALL be written to result on that same edge.
  - result SHALL NOT change at any other time.
REQ-009 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
  - Latency: done is high in the 5th cycle after the start-sampling edge.
REQ-010 start SHALL be ignored while busy=1, including during DONE.
  - Back-to-back ops: minimum spacing is 6 cycles, start edge to start edge.
REQ-011 pad=0 flags SHALL update on the same edge as result:
  - Z = (result == 16'h0000)
  - N = result[15]
  - V(add) = (a15 == b15) and (r15 != a15)
  - V(sub) = (a15 != b15) and (r15 != a15).
REQ-012 When pad=1, flag_z, flag_v and flag_n SHALL hold their previous values.
REQ-013 Operand inputs SHALL be ignored after the latch edge; changes during RUN have no effect.

Reset
REQ-014 rst_n=0 SHALL immediately, without waiting for clk, force:
  - state = IDLE
  - busy = 0, done = 0
  - result = 16'h0000
  - flag_z = 0, flag_v = 0, flag_n = 0
  - nibble index = 0, carry register = 0.
REQ-015 Reset asserted during RUN or DONE SHALL abandon the operation with no done pulse.
  - The first start after rst_n deasserts SHALL behave as from power-up.

Verification
REQ-016 The bench SHALL cover these scenarios:
  - V1: pad=0, sub=0, a=16'h7FFF, b=16'h0001 -> result=16'h8000, V=1, N=1, Z=0; done in 5th cycle after start edge; busy high for exactly 5 cycles.
  - V2: pad=0, sub=1, a=16'h0000, b=16'h0001 -> result=16'hFFFF, V=0, N=1, Z=0 (borrow crosses all nibbles).
  - V3: pad=0, sub=1, a=16'h1234, b=16'h1234 -> result=16'h0000, Z=1, V=0, N=0.
  - V3 continued: then a=16'h8000, b=16'h0001 -> result=16'h7FFF, V=1.
  - V4: pad=1, sub=0, a=16'h783F, b=16'h1821 -> result=16'h7850.
    - lane 3 saturates positive; lane 2 saturates negative; lane 0 wraps to 0 without carry into lane 1
    - flags unchanged from the prior op.
  - V5: start pulsed on every cycle of an op (RUN and DONE) with different operands -> exactly one done, and the result matches the first operands only.
  - V6: rst_n low for 1 cycle during RUN index 2 -> busy=0, done=0, result=16'h0000 without waiting for clk; no done pulse; a subsequent 16'h0003+16'h0004 yields 16'h0007.
